// File: rtl/led_flash_pkg.sv
// Shared definitions for the LED flasher: config mode encodings, channel
// states, the default prescale, and the mode-to-state mapping.
package led_flash_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam int PRESCALE_DEFAULT = 50000;

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_ON    = 2'b01,
        S_BLINK = 2'b10,
        S_BURST = 2'b11
    } ch_state_t;

    function automatic ch_state_t mode_to_state(input logic [1:0] mode);
        ch_state_t st;
        case (mode)
            MODE_ON:    st = S_ON;
            MODE_BLINK: st = S_BLINK;
            MODE_BURST: st = S_BURST;
            default:    st = S_OFF;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle time-base tick every PRESCALE
// clocks; sync_clr_i restarts the count (phase-sync builds only).
module led_tick_gen
    import led_flash_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_clr_i,
    output logic tick_o
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on sync, wrap at LAST, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr_i) begin
            cnt_d = '0;
        end else if (cnt_q >= LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/led_flash_array.sv
// Multi-channel LED flasher (OFF/ON/BLINK/BURST per channel) on a shared tick.
// Optional macro LED_PHASE_SYNC_EN adds SYNC_In to realign prescaler and phases.
module led_flash_array
    import led_flash_pkg::*;
#(
    parameter  int CH_NUM   = 4,
    parameter  int PER_W    = 16,
    parameter  int BURST_W  = 8,
    parameter  int PRESCALE = PRESCALE_DEFAULT,
    localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic               CLK,
    input  logic               RST,
`ifdef LED_PHASE_SYNC_EN
    input  logic               SYNC_In,
`endif
    input  logic               CFG_We,
    input  logic [CH_W-1:0]    CFG_Ch,
    input  logic [1:0]         CFG_Mode,
    input  logic [PER_W-1:0]   CFG_Period,
    input  logic [PER_W-1:0]   CFG_Duty,
    input  logic [BURST_W-1:0] CFG_Burst,
    output logic [CH_NUM-1:0]  LED_Out,
    output logic [CH_NUM-1:0]  Busy_Out,
    output logic [CH_NUM-1:0]  Done_Out
);

    logic tick_s;
    logic sync_s;
    logic wr_ok_s;

`ifdef LED_PHASE_SYNC_EN
    assign sync_s = SYNC_In;
`else
    assign sync_s = 1'b0;
`endif

    assign wr_ok_s = CFG_We && (int'(CFG_Ch) < CH_NUM);

    led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk_i      (CLK),
        .rst_i      (RST),
        .sync_clr_i (sync_s),
        .tick_o     (tick_s)
    );

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        ch_state_t          state_q, state_d;
        logic [PER_W-1:0]   period_q, period_d;
        logic [PER_W-1:0]   duty_q, duty_d;
        logic [PER_W-1:0]   phase_q, phase_d;
        logic [PER_W-1:0]   last_s;
        logic [BURST_W-1:0] remain_q, remain_d;
        logic               led_q, led_d;
        logic               busy_q, busy_d;
        logic               done_q, done_d;
        logic               wr_s;
        logic               run_s;

        assign wr_s   = wr_ok_s && (CFG_Ch == CH_W'(i));
        assign run_s  = (state_q == S_BLINK) || (state_q == S_BURST);
        // A period of 0 behaves as 1, so the last phase is 0 either way.
        assign last_s = (period_q == '0) ? '0 : (period_q - PER_W'(1));

        // Next state: a write beats sync, sync beats tick.
        always_comb begin
            state_d  = state_q;
            period_d = period_q;
            duty_d   = duty_q;
            phase_d  = phase_q;
            remain_d = remain_q;
            done_d   = 1'b0;
            if (wr_s) begin
                period_d = CFG_Period;
                duty_d   = CFG_Duty;
                phase_d  = '0;
                remain_d = CFG_Burst;
                if ((CFG_Mode == MODE_BURST) && (CFG_Burst == '0)) begin
                    state_d = S_OFF;
                    done_d  = 1'b1;
                end else begin
                    state_d = mode_to_state(CFG_Mode);
                end
            end else if (run_s && sync_s) begin
                phase_d = '0;
            end else if (run_s && tick_s) begin
                if (phase_q >= last_s) begin
                    phase_d = '0;
                    if (state_q == S_BURST) begin
                        if (remain_q <= BURST_W'(1)) begin
                            state_d  = S_OFF;
                            remain_d = '0;
                            done_d   = 1'b1;
                        end else begin
                            remain_d = remain_q - BURST_W'(1);
                        end
                    end else begin
                        remain_d = remain_q;
                    end
                end else begin
                    phase_d = phase_q + PER_W'(1);
                end
            end else begin
                phase_d = phase_q;
            end

            case (state_d)
                S_ON:             led_d = 1'b1;
                S_BLINK, S_BURST: led_d = (phase_d < duty_d);
                default:          led_d = 1'b0;
            endcase
            busy_d = (state_d == S_BURST);
        end

        // Channel registers; outputs are taken from next-state values so they
        // all change on the same edge as the state.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q  <= S_OFF;
                period_q <= '0;
                duty_q   <= '0;
                phase_q  <= '0;
                remain_q <= '0;
                led_q    <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                period_q <= period_d;
                duty_q   <= duty_d;
                phase_q  <= phase_d;
                remain_q <= remain_d;
                led_q    <= led_d;
                busy_q   <= busy_d;
                done_q   <= done_d;
            end
        end

        assign LED_Out[i]  = led_q;
        assign Busy_Out[i] = busy_q;
        assign Done_Out[i] = done_q;
    end

endmodule

// File: tb/tb_led_flash_array.sv
// Randomised + directed bench for led_flash_array with a tick-count reference
// model feeding a scoreboard queue that a separate monitor drains each cycle.
module tb_led_flash_array;

    localparam int CH_NUM   = 5;
    localparam int PER_W    = 16;
    localparam int BURST_W  = 8;
    localparam int PRESCALE = 4;
    localparam int CH_W     = 3;

    localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_BURST = 3;

    typedef struct {
        logic [CH_NUM-1:0] led;
        logic [CH_NUM-1:0] busy;
        logic [CH_NUM-1:0] done;
    } exp_t;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               sync_s = 1'b0;
    logic               CFG_We = 1'b0;
    logic [CH_W-1:0]    CFG_Ch = '0;
    logic [1:0]         CFG_Mode = '0;
    logic [PER_W-1:0]   CFG_Period = '0;
    logic [PER_W-1:0]   CFG_Duty = '0;
    logic [BURST_W-1:0] CFG_Burst = '0;
    logic [CH_NUM-1:0]  LED_Out;
    logic [CH_NUM-1:0]  Busy_Out;
    logic [CH_NUM-1:0]  Done_Out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t exp_q[$];

    // Reference model: each running channel counts ticks since its write.
    int m_pc;
    int m_mode [CH_NUM];
    int m_t    [CH_NUM];
    int m_per  [CH_NUM];
    int m_duty [CH_NUM];
    int m_burst[CH_NUM];

    led_flash_array #(
        .CH_NUM(CH_NUM), .PER_W(PER_W), .BURST_W(BURST_W), .PRESCALE(PRESCALE)
    ) dut (
        .CLK(CLK),
        .RST(RST),
`ifdef LED_PHASE_SYNC_EN
        .SYNC_In(sync_s),
`endif
        .CFG_We(CFG_We),
        .CFG_Ch(CFG_Ch),
        .CFG_Mode(CFG_Mode),
        .CFG_Period(CFG_Period),
        .CFG_Duty(CFG_Duty),
        .CFG_Burst(CFG_Burst),
        .LED_Out(LED_Out),
        .Busy_Out(Busy_Out),
        .Done_Out(Done_Out)
    );

    always #5 CLK = ~CLK;

    task automatic model(input bit rs, input bit we, input int ch, input int mode,
                         input int per, input int duty, input int burst, input bit sy);
        exp_t e;
        bit   tick;
        int   pe;
        tick   = (m_pc == PRESCALE - 1);
        e.done = '0;
        if (rs) begin
            m_pc = 0;
            for (int c = 0; c < CH_NUM; c++) begin
                m_mode[c] = M_OFF; m_t[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_burst[c] = 0;
            end
        end else begin
            m_pc = sy ? 0 : (m_pc + 1) % PRESCALE;
            for (int c = 0; c < CH_NUM; c++) begin
                bit run;
                run = (m_mode[c] == M_BLINK) || (m_mode[c] == M_BURST);
                pe  = (m_per[c] == 0) ? 1 : m_per[c];
                if (we && ch == c) begin
                    m_mode[c] = mode; m_t[c] = 0; m_per[c] = per;
                    m_duty[c] = duty; m_burst[c] = burst;
                    if (mode == M_BURST && burst == 0) begin
                        m_mode[c] = M_OFF;
                        e.done[c] = 1'b1;
                    end
                end else if (run && sy) begin
                    m_t[c] = (m_t[c] / pe) * pe;
                end else if (run && tick) begin
                    m_t[c]++;
                    if (m_mode[c] == M_BURST && (m_t[c] / pe) >= m_burst[c]) begin
                        m_mode[c] = M_OFF;
                        e.done[c] = 1'b1;
                    end
                end
            end
        end
        for (int c = 0; c < CH_NUM; c++) begin
            pe = (m_per[c] == 0) ? 1 : m_per[c];
            if (m_mode[c] == M_ON)
                e.led[c] = 1'b1;
            else if (m_mode[c] == M_BLINK || m_mode[c] == M_BURST)
                e.led[c] = ((m_t[c] % pe) < m_duty[c]);
            else
                e.led[c] = 1'b0;
            e.busy[c] = (m_mode[c] == M_BURST);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rs, input bit we, input int ch, input int mode,
                        input int per, input int duty, input int burst, input bit sy);
        @(posedge CLK);
        #3;
        RST        = rs;
        CFG_We     = we;
        CFG_Ch     = CH_W'(ch);
        CFG_Mode   = 2'(mode);
        CFG_Period = PER_W'(per);
        CFG_Duty   = PER_W'(duty);
        CFG_Burst  = BURST_W'(burst);
        sync_s     = sy;
        model(rs, we, ch, mode, per, duty, burst, sy);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int ch, input int mode, input int per, input int duty, input int burst);
        step(1'b0, 1'b1, ch, mode, per, duty, burst, 1'b0);
    endtask

    // Monitor: one expectation per clock edge, checked 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (LED_Out !== e.led) begin
                    errors++;
                    $display("FAIL led cyc=%0d got=%b exp=%b", cyc, LED_Out, e.led);
                end
                checks++;
                if (Busy_Out !== e.busy) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, Busy_Out, e.busy);
                end
                checks++;
                if (Done_Out !== e.done) begin
                    errors++;
                    $display("FAIL done cyc=%0d got=%b exp=%b", cyc, Done_Out, e.done);
                end
            end
        end
    end

    initial begin
        m_pc = 0;
        for (int c = 0; c < CH_NUM; c++) begin
            m_mode[c] = M_OFF; m_t[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_burst[c] = 0;
        end

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        idle(5);

        // Reset in the middle of a blink, then a long quiet stretch.
        wr(1, M_BLINK, 10, 3, 0);
        idle(20);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        idle(1000);

        wr(1, M_BLINK, 10, 3, 0);
        idle(100);
        wr(1, M_OFF, 0, 0, 0);

        wr(0, M_BURST, 4, 2, 3);
        idle(70);

        // Duty/period boundaries, zero burst, out-of-range channel.
        wr(2, M_BLINK, 10, 0, 0);
        wr(3, M_BLINK, 10, 10, 0);
        wr(4, M_BLINK, 0, 1, 0);
        idle(50);
        wr(0, M_BURST, 6, 3, 0);
        idle(5);
        wr(5, M_ON, 0, 0, 0);
        idle(5);
        wr(7, M_ON, 0, 0, 0);
        idle(5);

        // Abort a burst with an ON write.
        wr(2, M_BURST, 5, 2, 4);
        idle(15);
        wr(2, M_ON, 0, 0, 0);
        idle(10);

        // Write landing on a tick cycle.
        while (m_pc != PRESCALE - 1) idle(1);
        wr(3, M_BLINK, 3, 1, 0);
        idle(30);

`ifdef LED_PHASE_SYNC_EN
        wr(0, M_BLINK, 8, 4, 0);
        idle(12);
        wr(1, M_BLINK, 8, 4, 0);
        idle(40);
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        idle(80);
`endif

        for (int k = 0; k < 3000; k++) begin
            bit sy;
            sy = 1'b0;
`ifdef LED_PHASE_SYNC_EN
            sy = ($urandom_range(49, 0) == 0);
`endif
            if ($urandom_range(7, 0) == 0)
                step(1'b0, 1'b1, $urandom_range(7, 0), $urandom_range(3, 0),
                     $urandom_range(12, 0), $urandom_range(13, 0), $urandom_range(4, 0), sy);
            else if ($urandom_range(499, 0) == 0)
                step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
            else
                step(1'b0, 1'b0, 0, 0, 0, 0, 0, sy);
        end
        idle(2);

        @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_flash_array.md
Name: led_flash_array

Overview:
Multi-channel LED flasher, parametrised in channel count and counter width. A shared prescaler produces a time-base tick. Each channel has its own period, duty, mode and burst count, programmed through a single-cycle config write port. It sits between a control/register block and the board LED pins.

Parameters:
CH_NUM, 4, number of LED channels (1..16)
PER_W, 16, width of period/duty/phase counters, in ticks
BURST_W, 8, width of burst count
PRESCALE, 50000, CLK cycles per tick (1 ms at 50 MHz); must be >=1
CH_W, $clog2(CH_NUM) (min 1), channel-select width (localparam)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
CFG_We  in  1  config write strobe, one cycle per write
CFG_Ch  in  CH_W  target channel
CFG_Mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST
CFG_Period  in  PER_W  period in ticks
CFG_Duty  in  PER_W  on-time in ticks
CFG_Burst  in  BURST_W  number of periods in BURST mode
LED_Out  out  CH_NUM  registered LED drive, 1 = lit
Busy_Out  out  CH_NUM  1 while channel is in BURST
Done_Out  out  CH_NUM  one-cycle pulse when a burst completes

Behaviour:
- Reset: prescaler=0; all channels in S_OFF; period/duty/phase/remaining=0; LED_Out=0, Busy_Out=0, Done_Out=0.
- Prescaler: free-running 0..PRESCALE-1; tick is a one-cycle pulse on the cycle count==PRESCALE-1; wraps to 0. Config writes never reset it.
- Per-channel FSM states: S_OFF, S_ON, S_BLINK, S_BURST.
- Write: CFG_We=1 with CFG_Ch<CH_NUM latches mode/period/duty/burst and sets phase=0. The state becomes the mode's state on the next edge. CFG_Ch>=CH_NUM: write ignored.
- Period 0 is treated as period 1.
- Phase: in S_BLINK/S_BURST, on each tick phase increments and wraps from period-1 to 0.
- LED rule, registered, visible the cycle after state/phase changes:
  - S_OFF -> 0
  - S_ON -> 1
  - S_BLINK/S_BURST -> (phase < duty)
- Duty boundaries: duty=0 gives constant 0; duty>=period gives constant 1.
- BURST:
  - remaining=CFG_Burst on write; decrements on each phase wrap.
  - On the wrap where remaining==1: state -> S_OFF, LED 0, Done pulses 1 cycle, Busy 0, all on the same cycle.
  - CFG_Burst=0: enter S_OFF directly; Done pulses the cycle after the write.
- Busy_Out = (state==S_BURST), registered.
- Rewrite of a channel during BURST aborts it: no Done pulse; Busy reflects the new mode next cycle.
- Write and tick on the same cycle for the same channel: the write wins and the tick is ignored for that channel. Other channels are unaffected.
- Channels are fully independent apart from sharing the tick.
- Reset asserted mid-operation: immediate return to reset values, no Done pulse.

Optional Feature:
LED_PHASE_SYNC_EN
- Defined:
  - Adds input SYNC_In (1 bit).
  - SYNC_In=1 for a cycle resets the prescaler to 0 and sets phase=0 in every channel in S_BLINK/S_BURST on the next edge.
  - Burst remaining is unchanged, and no wrap/decrement is counted for the sync.
  - Config write to a channel on the same cycle: the write wins for that channel.
- Undefined: no SYNC_In port; no realignment logic.

Decomposition:
- Package led_flash_pkg holds:
  - mode encodings MODE_OFF/ON/BLINK/BURST
  - state typedef
  - default PRESCALE constant
- Sub-module led_tick_gen: prescaler, parameter PRESCALE, outputs tick. It has a sync clear input, used only under LED_PHASE_SYNC_EN.
- Per-channel logic is a generate loop in led_flash_array.

Test Plan:
- Reset: hold RST 5 cycles mid-blink, release -> LED_Out, Busy_Out, Done_Out all 0. Still all 0 after 1000 cycles with no writes.
- PRESCALE=4, ch1 BLINK period=10 duty=3 -> measured from the first tick after the write: LED high 12 cycles, low 28, repeat every 40. Channels 0, 2, 3 stay 0.
- PRESCALE=4, ch0 BURST period=4 duty=2 burst=3:
  - Busy=1 from the cycle after the write.
  - 3 pulses of 8 cycles high.
  - On the 3rd wrap, Done=1 for exactly 1 cycle, and Busy and LED go 0 together.
- Boundaries:
  - duty=0 -> constant 0.
  - duty=10 with period=10 -> constant 1.
  - period=0 duty=1 -> constant 1.
  - BURST burst=0 -> Done pulse the cycle after the write, LED 0.
  - CFG_Ch=CH_NUM -> no change.
- Abort and collision:
  - ch2 BURST, rewrite ON mid-burst -> Busy 0 and LED 1 next cycle, no Done.
  - Write coincident with tick -> phase=0 after the edge.
- With LED_PHASE_SYNC_EN: ch0/ch1 BLINK period=8 duty=4 started 3 ticks apart; pulse SYNC_In -> LED edges of both channels coincide thereafter.
